// File: rtl/yuv422_fb_pkg.sv
// Shared types and byte-lane layout for the YUV422 (UYVY) framebuffer.
// The lane constants are also used by the framebuffer read-side unpacking.
package yuv422_fb_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    DROP     = 2'd2
  } fb_wr_state_e;

  typedef logic [1:0] lane_t;

  localparam int unsigned LANE_BITS = 8;
  localparam int unsigned WORD_BITS = 32;

  // UYVY byte order within one packed 32-bit word
  localparam lane_t LANE_U  = 2'd0;
  localparam lane_t LANE_Y0 = 2'd1;
  localparam lane_t LANE_V  = 2'd2;
  localparam lane_t LANE_Y1 = 2'd3;

  function automatic int unsigned lane_lsb(input lane_t lane);
    return LANE_BITS * 32'(lane);
  endfunction

endpackage

// File: rtl/yuv422_byte_packer.sv
// Lane counter plus assembly register: packs four stream bytes into one word.
// clear with byte_en restarts the word with the current byte in lane 0.
module yuv422_byte_packer
  import yuv422_fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 byte_en,
  input  logic [LANE_BITS-1:0] byte_in,
  output logic                 word_valid_c,
  output logic [WORD_BITS-1:0] word_c
);

  lane_t                lane_q;
  lane_t                eff_lane;
  logic [WORD_BITS-1:0] asm_q;

  assign eff_lane     = clear ? LANE_U : lane_q;
  assign word_valid_c = byte_en && (eff_lane == LANE_Y1);

  // The word completes combinationally with the last-lane byte
  always_comb begin
    word_c = asm_q;
    word_c[lane_lsb(LANE_Y1) +: LANE_BITS] = byte_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= LANE_U;
      asm_q  <= '0;
    end else if (byte_en) begin
      asm_q[lane_lsb(eff_lane) +: LANE_BITS] <= byte_in;
      lane_q <= lane_t'(eff_lane + lane_t'(1));
    end else if (clear) begin
      lane_q <= LANE_U;
    end
  end

endmodule

// File: rtl/yuv422_fb_writer.sv
// UYVY byte stream to framebuffer word writer with frame alignment and freeze.
// Optional FB_WR_STATS_EN adds completed-frame and dropped-frame counters.
module yuv422_fb_writer
  import yuv422_fb_pkg::*;
#(
  parameter  int unsigned PIXELS   = 1280*760,
  localparam int unsigned ADR_BITS = $clog2(PIXELS)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [7:0]          s_data_i,
  input  logic                s_sof_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic                freeze_i,
  output logic [ADR_BITS-1:0] wr_addr_o,
  output logic [31:0]         wr_d_o,
  output logic                wr_en_o,
  output logic                frame_done_o,
`ifdef FB_WR_STATS_EN
  output logic [15:0]         frames_o,
  output logic [15:0]         drops_o,
`endif
  output logic                sync_err_o
);

  localparam int unsigned WORDS     = PIXELS / 2;
  localparam int unsigned DROP_BITS = $clog2(2*PIXELS) + 1;
  localparam logic [ADR_BITS-1:0]  LAST_WORD = ADR_BITS'(WORDS - 1);
  localparam logic [DROP_BITS-1:0] LAST_DROP = DROP_BITS'(2*PIXELS - 1);

  fb_wr_state_e         state_q, state_d;
  logic [ADR_BITS-1:0]  wcnt_q, wcnt_d;
  logic [DROP_BITS-1:0] dcnt_q, dcnt_d;
  logic                 acc;
  logic                 pk_clear, pk_en, word_valid_c;
  logic [31:0]          word_c;
  logic                 write_c, done_c, err_c, frozen_c;

  assign acc = s_valid_i && s_ready_o;

  yuv422_byte_packer u_packer (
    .clk          (clk_i),
    .rst_n        (rst_n_i),
    .clear        (pk_clear),
    .byte_en      (pk_en),
    .byte_in      (s_data_i),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= WAIT_SOF;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // An SOF restarts the frame from any state; only FILL flags it as an error
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    dcnt_d   = dcnt_q;
    pk_clear = 1'b0;
    pk_en    = 1'b0;
    write_c  = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
    frozen_c = 1'b0;
    if (acc) begin
      if (s_sof_i) begin
        err_c    = (state_q == FILL);
        wcnt_d   = '0;
        pk_clear = 1'b1;
        if (freeze_i) begin
          state_d  = DROP;
          dcnt_d   = DROP_BITS'(1);
          frozen_c = 1'b1;
        end else begin
          state_d = FILL;
          pk_en   = 1'b1;
        end
      end else begin
        case (state_q)
          FILL: begin
            pk_en = 1'b1;
            if (word_valid_c) begin
              write_c = 1'b1;
              if (wcnt_q == LAST_WORD) begin
                done_c  = 1'b1;
                state_d = WAIT_SOF;
                wcnt_d  = '0;
              end else begin
                wcnt_d = wcnt_q + ADR_BITS'(1);
              end
            end
          end
          DROP: begin
            if (dcnt_q == LAST_DROP) begin
              state_d = WAIT_SOF;
              dcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + DROP_BITS'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_ready_o    <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_d_o       <= '0;
      wr_addr_o    <= '0;
      frame_done_o <= 1'b0;
      sync_err_o   <= 1'b0;
    end else begin
      s_ready_o    <= 1'b1;
      wr_en_o      <= write_c;
      frame_done_o <= done_c;
      sync_err_o   <= err_c;
      if (write_c) begin
        wr_d_o    <= word_c;
        wr_addr_o <= wcnt_q;
      end
    end
  end

`ifdef FB_WR_STATS_EN
  logic [16:0] drops_sum;

  // A frozen restart that also truncates a frame counts both frames
  assign drops_sum = 17'(drops_o) + 17'(frozen_c) + 17'(err_c);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frames_o <= '0;
      drops_o  <= '0;
    end else begin
      if (done_c) frames_o <= frames_o + 16'd1;
      drops_o <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_yuv422_fb_writer.sv
// Directed self-checking bench for yuv422_fb_writer with PIXELS=8 (4 words/frame).
// Define FB_WR_STATS_EN to also check the frame/drop counters.
module tb_yuv422_fb_writer;

  localparam int unsigned PIXELS   = 8;
  localparam int unsigned ADR_BITS = $clog2(PIXELS);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          s_data = '0;
  logic                s_sof = 1'b0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic                freeze = 1'b0;
  logic [ADR_BITS-1:0] wr_addr;
  logic [31:0]         wr_d;
  logic                wr_en;
  logic                frame_done;
  logic                sync_err;
`ifdef FB_WR_STATS_EN
  logic [15:0]         frames;
  logic [15:0]         drops;
  logic [15:0]         frames_base;
  logic [15:0]         drops_base;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // write log captured by the monitor
  int          wn;
  logic [31:0] wd   [16];
  int          wa   [16];
  int          wcyc [16];
  logic [31:0] mem  [4];
  int          done_cnt, err_cnt, done_addr, done_alone;

  yuv422_fb_writer #(.PIXELS(PIXELS)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .s_data_i     (s_data),
    .s_sof_i      (s_sof),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .freeze_i     (freeze),
    .wr_addr_o    (wr_addr),
    .wr_d_o       (wr_d),
    .wr_en_o      (wr_en),
    .frame_done_o (frame_done),
`ifdef FB_WR_STATS_EN
    .frames_o     (frames),
    .drops_o      (drops),
`endif
    .sync_err_o   (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (wn < 16) begin
          wd[wn]   = wr_d;
          wa[wn]   = int'(wr_addr);
          wcyc[wn] = cyc;
        end
        if (wr_addr < 3'd4) mem[wr_addr[1:0]] = wr_d;
        wn++;
      end
      if (sync_err) err_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_addr = int'(wr_addr);
        if (!wr_en) done_alone++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wn = 0; done_cnt = 0; err_cnt = 0; done_addr = -1; done_alone = 0;
    for (int i = 0; i < 4; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  // one accepted byte per call; valid stays high until idle()
  task automatic send_byte(input logic [7:0] d, input logic sof, input logic frz);
    s_data = d; s_sof = sof; freeze = frz; s_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic frz);
    for (int i = 0; i < 16; i++) send_byte(base + 8'(i), (i == 0), frz);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_sof = 1'b0; freeze = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",   32'(s_ready),    32'd0);
    check("rst_wr_en",   32'(wr_en),      32'd0);
    check("rst_wr_d",    wr_d,            32'd0);
    check("rst_addr",    32'(wr_addr),    32'd0);
    check("rst_done",    32'(frame_done), 32'd0);
    check("rst_err",     32'(sync_err),   32'd0);
`ifdef FB_WR_STATS_EN
    check("rst_frames",  32'(frames),     32'd0);
    check("rst_drops",   32'(drops),      32'd0);
`endif
    rst_n = 1'b1;
    idle(2);
    check("ready_after", 32'(s_ready), 32'd1);

    // basic frame
    clear_log();
    send_frame(8'h00, 1'b0);
    idle(2);
    check("t1_writes", 32'(wn), 32'd4);
    check("t1_a0", mem[0], 32'h03020100);
    check("t1_a1", mem[1], 32'h07060504);
    check("t1_a2", mem[2], 32'h0B0A0908);
    check("t1_a3", mem[3], 32'h0F0E0D0C);
    check("t1_done_cnt",  32'(done_cnt),  32'd1);
    check("t1_done_addr", 32'(done_addr), 32'd3);
    check("t1_done_alone", 32'(done_alone), 32'd0);

    // bytes before SOF are discarded
    clear_log();
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b0, 1'b0);
    send_frame(8'h10, 1'b0);
    idle(2);
    check("t2_writes",  32'(wn),    32'd4);
    check("t2_first_a", 32'(wa[0]), 32'd0);
    check("t2_a0", mem[0], 32'h13121110);
    check("t2_a3", mem[3], 32'h1F1E1D1C);

    // mid-frame SOF
    clear_log();
    for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i), (i == 0), 1'b0);
    send_frame(8'h20, 1'b0);
    idle(2);
    check("t3_writes",   32'(wn),      32'd5);
    check("t3_partial",  wd[0],        32'hA3A2A1A0);
    check("t3_err_cnt",  32'(err_cnt), 32'd1);
    check("t3_restart_a", 32'(wa[1]),  32'd0);
    check("t3_a1", mem[1], 32'h27262524);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);

    // frozen frame then normal frame
`ifdef FB_WR_STATS_EN
    frames_base = frames;
    drops_base  = drops;
`endif
    clear_log();
    send_frame(8'hC0, 1'b1);
    check("t4_frozen_writes", 32'(wn), 32'd0);
    send_frame(8'h60, 1'b0);
    idle(2);
    check("t4_writes",   32'(wn),       32'd4);
    check("t4_a2", mem[2], 32'h6B6A6968);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);
    check("t4_err_cnt",  32'(err_cnt),  32'd0);
`ifdef FB_WR_STATS_EN
    check("t4_frames_inc", 32'(frames - frames_base), 32'd1);
    check("t4_drops_inc",  32'(drops - drops_base),   32'd1);
`endif

    // asynchronous reset mid-frame
    clear_log();
    for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i), (i == 0), 1'b0);
    check("t5_pre_addr", 32'(wr_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(s_ready), 32'd0);
    check("t5_rst_wr_en", 32'(wr_en),   32'd0);
    check("t5_rst_wr_d",  wr_d,         32'd0);
    check("t5_rst_addr",  32'(wr_addr), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_log();
    for (int i = 0; i < 6; i++) send_byte(8'h90 + 8'(i), 1'b0, 1'b0);
    idle(2);
    check("t5_no_sof_writes", 32'(wn), 32'd0);
    send_frame(8'h30, 1'b0);
    idle(2);
    check("t5_writes", 32'(wn), 32'd4);
    check("t5_a1", mem[1], 32'h37363534);

    // back-to-back frames, valid held high throughout
    clear_log();
    send_frame(8'h40, 1'b0);
    send_frame(8'h50, 1'b0);
    idle(2);
    check("t6_writes",   32'(wn),       32'd8);
    check("t6_done_cnt", 32'(done_cnt), 32'd2);
    check("t6_first",    wd[0],         32'h43424140);
    check("t6_f2_addr0", 32'(wa[4]),    32'd0);
    check("t6_a3", mem[3], 32'h5F5E5D5C);
    for (int i = 1; i < 8; i++)
      check($sformatf("t6_gap%0d", i), 32'(wcyc[i] - wcyc[i-1]), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
